// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set request found scanning ptr, ptr+1, ... modulo NREQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester / sink bundle of the round-robin mux arbiter.
interface mux4_rr_arbiter_if
    import mux4_arb_pkg::*;
#(
    parameter int DW = 8
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic               out_rdy;
    logic [NREQ-1:0]    gnt;
    logic [SEL_W-1:0]   sel;
    logic [DW-1:0]      dout;
    logic               dout_vld;
    logic               busy;

    modport master (
        output req, din, out_rdy,
        input  gnt, sel, dout, dout_vld, busy
    );

    modport slave (
        input  req, din, out_rdy,
        output gnt, sel, dout, dout_vld, busy
    );

endinterface

// File: rtl/mux4_rr_arbiter_mux4_dw.sv
// DW-bit 4:1 data mux, purely combinational.
module mux4_dw
    import mux4_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [NREQ*DW-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    output logic [DW-1:0]      dout
);

    // Pick the channel slice addressed by sel.
    always_comb begin
        dout = din[int'(sel)*DW +: DW];
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux; bursts of up to MAX_BURST beats.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);

    localparam int             CW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [SEL_W-1:0] pick;
    logic [DW-1:0]    mux_y;
    logic             beat_vld;

    assign pick     = rr_pick(bus.req, ptr_q);
    assign beat_vld = (state_q == ST_GRANT) && bus.req[sel_q];

    mux4_dw #(.DW(DW)) u_mux (
        .din  (bus.din),
        .sel  (sel_q),
        .dout (mux_y)
    );

    // State, pointer, grant, select and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant from IDLE, count accepted beats, release on burst end or withdraw.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    sel_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel_q] || (bus.out_rdy && cnt_q == LAST)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end else if (bus.out_rdy) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Outputs: registered grant/select, gated mux data toward the sink.
    always_comb begin
        bus.gnt      = gnt_q;
        bus.sel      = sel_q;
        bus.busy     = (state_q == ST_GRANT);
        bus.dout_vld = beat_vld;
        bus.dout     = beat_vld ? mux_y : '0;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: table vectors, directed corner sequences, random vs. model.
module tb_mux4_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        out_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    mux4_rr_arbiter_if #(.DW(8)) bif4 ();
    mux4_rr_arbiter_if #(.DW(8)) bif1 ();

    assign bif4.req     = req;
    assign bif4.din     = din;
    assign bif4.out_rdy = out_rdy;
    assign bif1.req     = req;
    assign bif1.din     = din;
    assign bif1.out_rdy = out_rdy;

    mux4_rr_arbiter #(.DW(8), .MAX_BURST(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bif4.slave)
    );

    mux4_rr_arbiter #(.DW(8), .MAX_BURST(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the mux, how many beats it has delivered, next priority.
    typedef struct {
        int owner;   // -1 when no grant
        int sel;
        int ptr;
        int beats;
    } model_t;

    model_t m4 = '{-1, 0, 0, 0};
    model_t m1 = '{-1, 0, 0, 0};

    function automatic model_t model_next(model_t m, logic r, logic [3:0] rq, logic rdy, int mb);
        model_t n = m;
        if (r) begin
            n = '{-1, 0, 0, 0};
        end else if (m.owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int ch = (m.ptr + k) % 4;
                if (n.owner < 0 && rq[ch]) begin
                    n.owner = ch;
                    n.sel   = ch;
                    n.beats = 0;
                end
            end
        end else if (!rq[m.owner]) begin
            n.ptr   = (m.owner + 1) % 4;
            n.owner = -1;
        end else if (rdy) begin
            n.beats = m.beats + 1;
            if (n.beats == mb) begin
                n.ptr   = (m.owner + 1) % 4;
                n.owner = -1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 <= model_next(m4, rst, req, out_rdy, 4);
        m1 <= model_next(m1, rst, req, out_rdy, 1);
    end

    // Packed view {gnt, sel, busy, dout_vld, dout} the model predicts for current inputs.
    function automatic logic [15:0] exp_out(model_t m, logic [3:0] rq, logic [31:0] d);
        logic [3:0] g;
        logic       b;
        logic       v;
        logic [7:0] o;
        b = (m.owner >= 0);
        g = b ? 4'(1 << m.owner) : 4'h0;
        v = b ? rq[m.owner] : 1'b0;
        o = v ? d[m.owner*8 +: 8] : 8'h00;
        return {g, 2'(m.sel), b, v, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_b4", {16'h0, bif4.gnt, bif4.sel, bif4.busy, bif4.dout_vld, bif4.dout},
            {16'h0, exp_out(m4, req, din)});
        chk("model_b1", {16'h0, bif1.gnt, bif1.sel, bif1.busy, bif1.dout_vld, bif1.dout},
            {16'h0, exp_out(m1, req, din)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'h0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int beats;
        int n;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int n;

        // Reset hold with all requests, then a single-channel burst and its regrant.
        tbl[0] = '{1'b1, 4'b1111, 1'b1, 32'h44332211, {4'b0000, 2'd0, 1'b0, 1'b0, 8'h00}};
        tbl[1] = '{1'b1, 4'b1111, 1'b1, 32'h44332211, {4'b0000, 2'd0, 1'b0, 1'b0, 8'h00}};
        tbl[2] = '{1'b0, 4'b1111, 1'b1, 32'h44332211, {4'b0001, 2'd0, 1'b1, 1'b1, 8'h11}};
        tbl[3] = '{1'b1, 4'b0000, 1'b1, 32'h44332211, {4'b0000, 2'd0, 1'b0, 1'b0, 8'h00}};
        tbl[4] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}};
        tbl[5] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}};
        tbl[6] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}};
        tbl[7] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}};
        tbl[8] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0000, 2'd2, 1'b0, 1'b0, 8'h00}};
        tbl[9] = '{1'b0, 4'b0100, 1'b1, 32'h44A52211, {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}};

        rst     = 1'b1;
        req     = 4'h0;
        din     = 32'h0;
        out_rdy = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rst     = tbl[i].rst;
            req     = tbl[i].req;
            out_rdy = tbl[i].rdy;
            din     = tbl[i].din;
            step();
            chk($sformatf("vec%0d", i),
                {16'h0, bif4.gnt, bif4.sel, bif4.busy, bif4.dout_vld, bif4.dout},
                {16'h0, tbl[i].exp});
        end

        // All channels requesting: rotation 0,1,2,3,0 with four beats and one bubble each.
        din     = 32'hD4C3B2A1;
        out_rdy = 1'b1;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bif4.busy !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("rot_bubble%0d", g), n, 1);
            chk($sformatf("rot_gnt%0d", g), {28'h0, bif4.gnt}, 32'(1 << (g % 4)));
            beats = 0;
            n     = 0;
            while (bif4.busy === 1'b1 && n < 20) begin
                if (bif4.dout_vld && out_rdy) beats++;
                step();
                n++;
            end
            chk($sformatf("rot_beats%0d", g), beats, 4);
        end

        // Sink stall after two beats: valid held, burst still totals four accepted beats.
        do_reset();
        req = 4'b0001;
        step();
        chk("stall_gnt", {28'h0, bif4.gnt}, 32'h1);
        beats = 0;
        for (int k = 0; k < 2; k++) begin
            if (bif4.dout_vld && out_rdy) beats++;
            step();
        end
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_hold%0d", k), {30'h0, bif4.busy, bif4.dout_vld}, 32'h3);
        end
        out_rdy = 1'b1;
        n = 0;
        while (bif4.busy === 1'b1 && n < 10) begin
            if (bif4.dout_vld && out_rdy) beats++;
            step();
            n++;
        end
        chk("stall_beats", beats, 4);
        chk("stall_idle", {28'h0, bif4.gnt}, 32'h0);

        // Requester withdraws after two beats; pointer moves past it.
        do_reset();
        req = 4'b0010;
        step();
        chk("wd_gnt", {28'h0, bif4.gnt}, 32'h2);
        step();
        step();
        req = 4'b0100;
        #1;
        chk("wd_novld", {31'h0, bif4.dout_vld}, 32'h0);
        step();
        chk("wd_exit", {27'h0, bif4.busy, bif4.gnt}, 32'h0);
        step();
        chk("wd_next", {28'h0, bif4.gnt}, 32'h4);

        // Reset in the middle of a ch3 burst.
        do_reset();
        req = 4'b1000;
        step();
        chk("mr_gnt", {28'h0, bif4.gnt}, 32'h8);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mr_reset", {16'h0, bif4.gnt, bif4.sel, bif4.busy, bif4.dout_vld, bif4.dout}, 32'h0);
        rst = 1'b0;
        step();
        chk("mr_regnt", {28'h0, bif4.gnt}, 32'h8);

        // Random traffic against the model, both burst lengths.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom % 8 == 0) req[ch] = ~req[ch];
            end
            din     = $urandom;
            out_rdy = ($urandom % 4) != 0;
            rst     = ($urandom % 128) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
